// File: rtl/video_line_udp_packer.sv
// video_line_udp_packer: captures active RGB565 lines into two ping-pong
// line RAMs and replays each one as a UDP payload byte stream. Each payload
// is an 8-byte header {MAGIC, frame_id, line_no, pix_cnt} followed by the
// pixels, high byte first.
`timescale 1ns/1ps
module video_line_udp_packer #(
  parameter int          H_ACTIVE = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] MAGIC    = 16'h5AA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vin_vs_n,
  input  logic        vin_de,
  input  logic [15:0] vin_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_sop,
  output logic        tx_last,
  output logic [15:0] tx_len,
  output logic [15:0] drop_cnt,
  output logic        busy
);

  localparam logic [15:0] PIX_MAX = 16'(H_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  logic        vs_q, de_q, wr_sel, wr_claim, rd_sel;
  logic [1:0]  buf_full;
  logic [15:0] pix_cnt, frame_id, line_no;
  logic [15:0] hdr_frame [2];
  logic [15:0] hdr_line  [2];
  logic [15:0] hdr_pix   [2];
  logic [15:0] line_ram  [2**(ADDR_W+1)];
  logic [15:0] rd_q;

  state_t      state, state_n;
  logic [2:0]  hdr_idx, hdr_idx_n;
  logic [15:0] pix_idx, pix_idx_n;
  logic        lo_byte, lo_byte_n;
  logic        buf_free, load_len, last_pix;
  logic [7:0]  hdr_byte;

  logic              vs_fall, de_rise, de_fall, wr_free, wr_en;
  logic [ADDR_W-1:0] wr_addr;

  assign vs_fall = vs_q & ~vin_vs_n;
  assign de_rise = vin_de & ~de_q;
  assign de_fall = ~vin_de & de_q;
  // A buffer released by the reader in this very cycle is already usable.
  assign wr_free = ~buf_full[wr_sel] | (buf_free & (rd_sel == wr_sel));
  assign wr_en   = vin_de & (de_rise ? wr_free : (wr_claim & (pix_cnt < PIX_MAX)));
  assign wr_addr = de_rise ? '0 : pix_cnt[ADDR_W-1:0];
  assign busy    = (|buf_full) | (state != S_IDLE);
  assign last_pix = (pix_idx == hdr_pix[rd_sel] - 16'd1);

  // Write-side control: edge detection, line claim/drop, frame and line counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
      wr_sel   <= 1'b0;
      wr_claim <= 1'b0;
      pix_cnt  <= '0;
      frame_id <= 16'hFFFF;
      line_no  <= '0;
      drop_cnt <= '0;
    end else begin
      vs_q <= vin_vs_n;
      de_q <= vin_de;
      if (de_rise) begin
        wr_claim <= wr_free;
        pix_cnt  <= wr_free ? 16'd1 : 16'd0;
        if (!wr_free && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else if (wr_en) begin
        pix_cnt <= pix_cnt + 16'd1;
      end
      if (de_fall) begin
        wr_claim <= 1'b0;
        if (wr_claim) wr_sel <= ~wr_sel;
      end
      if (vs_fall) begin
        frame_id <= frame_id + 16'd1;
        line_no  <= '0;
      end else if (de_fall) begin
        line_no <= line_no + 16'd1;
      end
    end
  end

  // Buffer ownership: writer marks full on line close, reader frees after the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full <= '0;
      rd_sel   <= 1'b0;
    end else begin
      if (buf_free) begin
        buf_full[rd_sel] <= 1'b0;
        rd_sel           <= ~rd_sel;
      end
      if (de_fall && wr_claim) buf_full[wr_sel] <= 1'b1;
    end
  end

  // Line RAM, per-buffer header latches and the registered RAM read port.
  always_ff @(posedge clk) begin
    if (wr_en) line_ram[{wr_sel, wr_addr}] <= vin_data;
    if (de_fall && wr_claim) begin
      hdr_frame[wr_sel] <= frame_id;
      hdr_line[wr_sel]  <= line_no;
      hdr_pix[wr_sel]   <= pix_cnt;
    end
    rd_q <= line_ram[{rd_sel, pix_idx_n[ADDR_W-1:0]}];
  end

  // Packet length is captured once per packet so it stays stable throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_len <= '0;
    else if (load_len) tx_len <= 16'd8 + {hdr_pix[rd_sel][14:0], 1'b0};
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      hdr_idx <= '0;
      pix_idx <= '0;
      lo_byte <= 1'b0;
    end else begin
      state   <= state_n;
      hdr_idx <= hdr_idx_n;
      pix_idx <= pix_idx_n;
      lo_byte <= lo_byte_n;
    end
  end

  // Header byte selection from the latches of the buffer being read.
  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx)
      3'd0: hdr_byte = MAGIC[15:8];
      3'd1: hdr_byte = MAGIC[7:0];
      3'd2: hdr_byte = hdr_frame[rd_sel][15:8];
      3'd3: hdr_byte = hdr_frame[rd_sel][7:0];
      3'd4: hdr_byte = hdr_line[rd_sel][15:8];
      3'd5: hdr_byte = hdr_line[rd_sel][7:0];
      3'd6: hdr_byte = hdr_pix[rd_sel][15:8];
      default: hdr_byte = hdr_pix[rd_sel][7:0];
    endcase
  end

  // Read FSM next state and stream outputs; the pixel index runs one read ahead
  // so PAY starts without bubbles and stalls simply re-read the same word.
  always_comb begin
    state_n   = state;
    hdr_idx_n = hdr_idx;
    pix_idx_n = pix_idx;
    lo_byte_n = lo_byte;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    tx_sop    = 1'b0;
    tx_last   = 1'b0;
    buf_free  = 1'b0;
    load_len  = 1'b0;
    case (state)
      S_IDLE: begin
        if (buf_full[rd_sel]) begin
          state_n   = S_HDR;
          hdr_idx_n = '0;
          pix_idx_n = '0;
          lo_byte_n = 1'b0;
          load_len  = 1'b1;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_sop   = (hdr_idx == 3'd0);
        if (tx_ready) begin
          if (hdr_idx == 3'd7) state_n = S_PAY;
          else hdr_idx_n = hdr_idx + 3'd1;
        end
      end
      default: begin
        tx_valid = 1'b1;
        tx_data  = lo_byte ? rd_q[7:0] : rd_q[15:8];
        tx_last  = lo_byte & last_pix;
        if (tx_ready) begin
          lo_byte_n = ~lo_byte;
          if (lo_byte) begin
            pix_idx_n = pix_idx + 16'd1;
            if (last_pix) begin
              buf_free = 1'b1;
              state_n  = S_IDLE;
            end
          end
        end
      end
    endcase
  end

endmodule
